wb_sdram_arbiter2: RTL and testbench

//  Two-master Wishbone B3 classic arbiter sharing the single SDRAM controller slave port in the
//  SoC. It sits in the wb_clk domain between CPU data master (m0) / DMA or I-fetch master (m1)
//  and the SDRAM wishbone port. Round-robin fair, holds grant for a whole bus cycle (cyc),
//  bus-watchdog aborts stalled slave transfers with an error to the owning master.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_bus_watchdog.sv | 48 ++++
 rtl/wb_sdram_arbiter2.sv | 156 +++++++++++++++
 tb/tb_wb_sdram_arbiter2.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and defaults for the two-master Wishbone SDRAM arbiter.
//   arb_state_t  : arbiter FSM states
//   master_idx_t : index of a Wishbone master (0 = m0, 1 = m1)
//   idx_to_grant : one-hot grant vector for a master index
package wb_arb_pkg;

  localparam int unsigned WB_AW      = 32;
  localparam int unsigned WB_DW      = 32;
  localparam int unsigned WB_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } arb_state_t;

  typedef logic master_idx_t;

  // One-hot grant encoding: bit N set means master N owns the slave
  function automatic logic [1:0] idx_to_grant(input master_idx_t idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/wb_bus_watchdog.sv
// Stalled-transfer watchdog for the SDRAM arbiter.
// Counts consecutive stalled cycles (strobe out, no ack/err back) and flags
// expiry in the cycle the count reaches TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0
// disables expiry entirely.
//   i_clock    : wb clock
//   i_reset    : synchronous active-high reset
//   i_stall    : current cycle is a stalled strobe cycle
//   o_expire_c : combinational, this stalled cycle reaches the limit
module wb_bus_watchdog
  import wb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_stall,
  output logic o_expire_c
);

  localparam int unsigned CW     = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic        ENABLE = (TIMEOUT_CYCLES != 0);

  logic [CW-1:0] r_count;
  logic [CW-1:0] w_count_next;

  // Any non-stalled cycle restarts the count; hold at the limit rather than wrap
  always_comb begin
    w_count_next = '0;
    if (i_stall) begin
      if (r_count == CW'(TIMEOUT_CYCLES)) begin
        w_count_next = r_count;
      end else begin
        w_count_next = r_count + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_expire_c = ENABLE & i_stall & (w_count_next == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wb_sdram_arbiter2.sv
// Two-master Wishbone B3 classic arbiter in front of the SDRAM controller port.
// Round-robin between m0 and m1, grant locked for a whole cyc, watchdog turns a
// stalled slave into an error to the owning master.
//   clock, reset           : wb clock, synchronous active-high reset
//   mN_adr/dat/sel/we/cyc/stb_i : master N request (N = 0,1)
//   mN_dat_o/ack_o/err_o   : response to master N (data broadcast, ack/err owner only)
//   s_adr/dat/sel/we/cyc/stb_o : request muxed from the current owner
//   s_dat_i/ack_i/err_i    : slave response
//   grant_o                : one-hot owner, 00 when idle
//   timeout_o              : one-cycle pulse on watchdog abort
module wb_sdram_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int unsigned AW             = WB_AW,
  parameter int unsigned DW             = WB_DW,
  parameter int unsigned TIMEOUT_CYCLES = WB_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  arb_state_t  r_state, w_state_next;
  master_idx_t r_owner, w_owner_next;
  master_idx_t r_last, w_last_next;
  logic        r_timeout, w_timeout_next;

  logic w_req0, w_req1;
  logic w_own_cyc, w_own_stb;
  logic w_stall, w_expire;
  logic w_ack, w_err;

  assign w_req0    = m0_cyc_i & m0_stb_i;
  assign w_req1    = m1_cyc_i & m1_stb_i;
  assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
  assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;

  // Stall is derived from state and inputs directly so the watchdog has no loop through the FSM
  assign w_stall = (r_state == BUSY) & w_own_cyc & w_own_stb & ~s_ack_i & ~s_err_i;

  wb_bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clock    (clock),
    .i_reset    (reset),
    .i_stall    (w_stall),
    .o_expire_c (w_expire)
  );

  // Arbitration, ownership and slave handshake gating
  always_comb begin
    w_state_next   = r_state;
    w_owner_next   = r_owner;
    w_last_next    = r_last;
    w_timeout_next = 1'b0;
    s_cyc_o        = 1'b0;
    s_stb_o        = 1'b0;
    w_ack          = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req0 | w_req1) begin
          w_state_next = BUSY;
          // On a tie the master that was not served last wins
          if (w_req0 & w_req1) begin
            w_owner_next = ~r_last;
          end else begin
            w_owner_next = w_req1;
          end
        end
      end
      BUSY: begin
        s_cyc_o = w_own_cyc;
        s_stb_o = w_own_cyc & w_own_stb;
        w_ack   = s_ack_i;
        w_err   = s_err_i;
        if (!w_own_cyc) begin
          w_state_next = IDLE;
          w_last_next  = r_owner;
        end else if (w_expire) begin
          w_state_next   = ERR;
          w_timeout_next = 1'b1;
        end
      end
      ERR: begin
        // Slave is detached; only the first ERR cycle signals the abort
        w_err = r_timeout;
        if (!w_own_cyc) begin
          w_state_next = IDLE;
          w_last_next  = r_owner;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_owner   <= 1'b0;
      r_last    <= 1'b1;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_owner   <= w_owner_next;
      r_last    <= w_last_next;
      r_timeout <= w_timeout_next;
    end
  end

  assign s_adr_o = r_owner ? m1_adr_i : m0_adr_i;
  assign s_dat_o = r_owner ? m1_dat_i : m0_dat_i;
  assign s_sel_o = r_owner ? m1_sel_i : m0_sel_i;
  assign s_we_o  = r_owner ? m1_we_i  : m0_we_i;

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign m0_ack_o = w_ack & ~r_owner;
  assign m1_ack_o = w_ack & r_owner;
  assign m0_err_o = w_err & ~r_owner;
  assign m1_err_o = w_err & r_owner;

  assign grant_o   = (r_state == IDLE) ? 2'b00 : idx_to_grant(r_owner);
  assign timeout_o = r_timeout;

endmodule

// File: tb/tb_wb_sdram_arbiter2.sv
// Bench for wb_sdram_arbiter2: directed scenarios with literal expectations,
// then randomized masters/slave, all checked every cycle against a
// transaction-level model of ownership, round-robin and stall counting.
module tb_wb_sdram_arbiter2;

  localparam int TO = 8;

  logic        clk;
  logic        rst;
  logic [1:0]  mc, ms, mwe;
  logic [31:0] madr [2];
  logic [31:0] mdat [2];
  logic [3:0]  msel [2];
  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, sdat;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, sack, serr;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_errors = 0;

  wb_sdram_arbiter2 #(.AW(32), .DW(32), .TIMEOUT_CYCLES(TO)) dut (
    .clock(clk), .reset(rst),
    .m0_adr_i(madr[0]), .m0_dat_i(mdat[0]), .m0_sel_i(msel[0]), .m0_we_i(mwe[0]),
    .m0_cyc_i(mc[0]), .m0_stb_i(ms[0]), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(madr[1]), .m1_dat_i(mdat[1]), .m1_sel_i(msel[1]), .m1_we_i(mwe[1]),
    .m1_cyc_i(mc[1]), .m1_stb_i(ms[1]), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(sdat), .s_ack_i(sack), .s_err_i(serr),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the slave (-1 none), whether the owner is in the aborted
  // phase, consecutive stalled strobes, and the last master served.
  int mdl_owner = -1, mdl_last = 1, mdl_wait = 0;
  bit mdl_in_err = 0, mdl_first = 0, mdl_valid = 0;
  int nx_owner = -1, nx_last = 1, nx_wait = 0;
  bit nx_in_err = 0, nx_first = 0, nx_valid = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_eval();
    logic [1:0] eg, eack, eerr;
    logic ecyc, estb, eto, r0, r1;
    int o;
    eg = 2'b00; eack = 2'b00; eerr = 2'b00; ecyc = 1'b0; estb = 1'b0; eto = 1'b0;
    o = mdl_owner;
    if (mdl_valid) begin
      if (o >= 0) begin
        eg = (o == 0) ? 2'b01 : 2'b10;
        if (mdl_in_err) begin
          eerr[o] = mdl_first;
          eto     = mdl_first;
        end else begin
          ecyc    = mc[o];
          estb    = mc[o] & ms[o];
          eack[o] = sack;
          eerr[o] = serr;
        end
      end
      chk("grant", 64'(grant_o), 64'(eg));
      chk("s_cyc", 64'(s_cyc_o), 64'(ecyc));
      chk("s_stb", 64'(s_stb_o), 64'(estb));
      chk("m0_ack", 64'(m0_ack_o), 64'(eack[0]));
      chk("m1_ack", 64'(m1_ack_o), 64'(eack[1]));
      chk("m0_err", 64'(m0_err_o), 64'(eerr[0]));
      chk("m1_err", 64'(m1_err_o), 64'(eerr[1]));
      chk("timeout", 64'(timeout_o), 64'(eto));
      chk("m0_dat", 64'(m0_dat_o), 64'(sdat));
      chk("m1_dat", 64'(m1_dat_o), 64'(sdat));
      if (estb) begin
        chk("s_adr", 64'(s_adr_o), 64'(madr[o]));
        chk("s_dat", 64'(s_dat_o), 64'(mdat[o]));
        chk("s_sel", 64'(s_sel_o), 64'(msel[o]));
        chk("s_we", 64'(s_we_o), 64'(mwe[o]));
      end
    end
    nx_owner = mdl_owner; nx_last = mdl_last; nx_wait = mdl_wait;
    nx_in_err = mdl_in_err; nx_first = 1'b0; nx_valid = mdl_valid;
    if (rst) begin
      nx_owner = -1; nx_last = 1; nx_wait = 0; nx_in_err = 1'b0; nx_valid = 1'b1;
    end else if (mdl_valid) begin
      if (o < 0) begin
        r0 = mc[0] & ms[0];
        r1 = mc[1] & ms[1];
        if (r0 && r1) nx_owner = (mdl_last == 0) ? 1 : 0;
        else if (r0)  nx_owner = 0;
        else if (r1)  nx_owner = 1;
        nx_wait = 0;
      end else if (!mc[o]) begin
        nx_last = o; nx_owner = -1; nx_wait = 0; nx_in_err = 1'b0;
      end else if (!mdl_in_err) begin
        nx_wait = (ms[o] && !sack && !serr) ? mdl_wait + 1 : 0;
        if (nx_wait == TO) begin
          nx_in_err = 1'b1; nx_first = 1'b1; nx_wait = 0;
        end
      end
    end
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    mdl_owner = nx_owner; mdl_last = nx_last; mdl_wait = nx_wait;
    mdl_in_err = nx_in_err; mdl_first = nx_first; mdl_valid = nx_valid;
    #1;
  endtask

  // Called after settle(); steps until a grant shows, bounded
  task automatic wait_grant(output logic [1:0] g);
    g = grant_o;
    for (int k = 0; k < 20 && g == 2'b00; k++) begin
      advance();
      settle();
      g = grant_o;
    end
  endtask

  task automatic new_beat(input int i);
    madr[i] = $urandom;
    mdat[i] = $urandom;
    msel[i] = 4'($urandom);
    mwe[i]  = 1'($urandom);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout at %0t", $time);
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [1:0] g, e, obs_ack, obs_err;
    int beats [2];
    int quiet, r;
    rst = 1'b1; mc = 2'b00; ms = 2'b00; mwe = 2'b00;
    for (int i = 0; i < 2; i++) begin madr[i] = '0; mdat[i] = '0; msel[i] = '0; end
    sdat = '0; sack = 1'b0; serr = 1'b0;

    // Reset state
    settle(); advance();
    settle();
    chk("rst_grant", 64'(grant_o), 64'h0);
    chk("rst_scyc", 64'(s_cyc_o), 64'h0);
    chk("rst_timeout", 64'(timeout_o), 64'h0);
    advance();
    rst = 1'b0;

    // m0 single read, ack on third granted cycle
    mc[0] = 1'b1; ms[0] = 1'b1; mwe[0] = 1'b0; madr[0] = 32'h100; msel[0] = 4'hF;
    settle(); chk("t1_arb_latency", 64'(grant_o), 64'h0); advance();
    settle(); chk("t1_grant", 64'(grant_o), 64'h1); chk("t1_sadr", 64'(s_adr_o), 64'h100); advance();
    settle(); advance();
    sack = 1'b1; sdat = 32'hDEADBEEF;
    settle();
    chk("t1_ack0", 64'(m0_ack_o), 64'h1);
    chk("t1_dat0", 64'(m0_dat_o), 64'hDEADBEEF);
    chk("t1_ack1", 64'(m1_ack_o), 64'h0);
    advance();
    sack = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0;
    settle(); chk("t1_scyc_drop", 64'(s_cyc_o), 64'h0); advance();
    settle(); chk("t1_idle", 64'(grant_o), 64'h0); advance();

    // Simultaneous requests from reset, then strict alternation
    rst = 1'b1; settle(); advance(); rst = 1'b0;
    mc = 2'b11; ms = 2'b11; madr[0] = 32'hA0; madr[1] = 32'hA1;
    for (int n = 0; n < 4; n++) begin
      settle(); wait_grant(g);
      e = (n % 2 == 0) ? 2'b01 : 2'b10;
      chk("t2_alternate", 64'(g), 64'(e));
      advance();
      sack = 1'b1;
      settle(); chk("t2_owner_ack", 64'(g == 2'b01 ? m0_ack_o : m1_ack_o), 64'h1); advance();
      sack = 1'b0;
      if (n == 3) begin mc = 2'b00; ms = 2'b00; end
      else if (g == 2'b01) begin mc[0] = 1'b0; ms[0] = 1'b0; end
      else begin mc[1] = 1'b0; ms[1] = 1'b0; end
      settle(); advance();
      if (n < 3) begin mc = 2'b11; ms = 2'b11; end
    end
    settle(); advance();

    // m1 4-beat burst locks out m0
    mc[1] = 1'b1; ms[1] = 1'b1; madr[1] = 32'hB000;
    settle(); wait_grant(g); chk("t3_grant_m1", 64'(g), 64'h2); advance();
    mc[0] = 1'b1; ms[0] = 1'b1; madr[0] = 32'hC000;
    for (int b = 0; b < 4; b++) begin
      sack = 1'b1;
      settle();
      chk("t3_beat_ack1", 64'(m1_ack_o), 64'h1);
      chk("t3_beat_ack0", 64'(m0_ack_o), 64'h0);
      chk("t3_hold", 64'(grant_o), 64'h2);
      advance();
      sack = 1'b0;
      if (b < 3) begin
        ms[1] = 1'b0;
        settle(); chk("t3_gap_hold", 64'(grant_o), 64'h2); chk("t3_gap_cyc", 64'(s_cyc_o), 64'h1); advance();
        ms[1] = 1'b1; madr[1] = madr[1] + 32'h4;
      end else begin
        mc[1] = 1'b0; ms[1] = 1'b0;
        settle(); advance();
      end
    end
    settle(); wait_grant(g); chk("t3_m0_after", 64'(g), 64'h1); advance();
    sack = 1'b1; settle(); advance();
    sack = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0; settle(); advance();
    settle(); advance();

    // Watchdog abort on m1 after TO stalled cycles
    mc[1] = 1'b1; ms[1] = 1'b1; madr[1] = 32'hD000;
    settle(); wait_grant(g); chk("t4_grant", 64'(g), 64'h2);
    for (int k = 2; k <= TO; k++) begin
      advance(); settle();
      chk("t4_no_timeout", 64'(timeout_o), 64'h0);
      chk("t4_stalling", 64'(s_stb_o), 64'h1);
    end
    advance();
    sack = 1'b1;
    settle();
    chk("t4_timeout", 64'(timeout_o), 64'h1);
    chk("t4_err1", 64'(m1_err_o), 64'h1);
    chk("t4_scyc_off", 64'(s_cyc_o), 64'h0);
    chk("t4_late_ack", 64'(m1_ack_o), 64'h0);
    advance();
    sack = 1'b0;
    settle(); chk("t4_pulse_end", 64'(timeout_o), 64'h0); chk("t4_err_hold", 64'(grant_o), 64'h2); advance();
    mc[1] = 1'b0; ms[1] = 1'b0;
    settle(); advance();
    settle(); chk("t4_idle", 64'(grant_o), 64'h0); advance();

    // Slave error on m0 write, then reset during m1 ownership
    mc[0] = 1'b1; ms[0] = 1'b1; mwe[0] = 1'b1; mdat[0] = 32'h12345678;
    settle(); wait_grant(g); chk("t5_grant0", 64'(g), 64'h1); advance();
    serr = 1'b1;
    settle(); chk("t5_err0", 64'(m0_err_o), 64'h1); chk("t5_no_timeout", 64'(timeout_o), 64'h0); advance();
    serr = 1'b0; mc[0] = 1'b0; ms[0] = 1'b0;
    settle(); advance();
    mc[1] = 1'b1; ms[1] = 1'b1;
    settle(); chk("t5_idle", 64'(grant_o), 64'h0); advance();
    settle(); chk("t5_grant1", 64'(grant_o), 64'h2); advance();
    rst = 1'b1;
    settle(); chk("t5_rst_pending", 64'(s_cyc_o), 64'h1); advance();
    rst = 1'b0; mc[0] = 1'b1; ms[0] = 1'b1;
    settle(); chk("t5_rst_grant", 64'(grant_o), 64'h0); chk("t5_rst_scyc", 64'(s_cyc_o), 64'h0); advance();
    settle(); chk("t5_tie_m0", 64'(grant_o), 64'h1); advance();
    mc = 2'b00; ms = 2'b00; mwe = 2'b00;
    settle(); advance();
    settle(); advance();

    // Randomized masters and slave
    beats[0] = 0; beats[1] = 0; quiet = 0; obs_ack = 2'b00; obs_err = 2'b00;
    for (int c = 0; c < 3000; c++) begin
      sdat = $urandom;
      if (quiet > 0) begin
        sack = 1'b0; serr = 1'b0; quiet--;
      end else begin
        r = $urandom_range(0, 99);
        sack = (r >= 10 && r < 50);
        serr = (r >= 50 && r < 54);
        if (r < 3) quiet = 12;
      end
      rst = ($urandom_range(0, 499) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!mc[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            mc[i] = 1'b1; ms[i] = 1'b1; beats[i] = $urandom_range(1, 4); new_beat(i);
          end
        end else if (obs_err[i]) begin
          mc[i] = 1'b0; ms[i] = 1'b0;
        end else if (obs_ack[i] && ms[i]) begin
          beats[i]--;
          if (beats[i] <= 0) begin
            mc[i] = 1'b0; ms[i] = 1'b0;
          end else begin
            ms[i] = 1'($urandom_range(0, 1)); new_beat(i);
          end
        end else if (!ms[i]) begin
          ms[i] = 1'b1;
        end else if ($urandom_range(0, 63) == 0) begin
          mc[i] = 1'b0; ms[i] = 1'b0;
        end
      end
      settle();
      obs_ack = {m1_ack_o, m0_ack_o};
      obs_err = {m1_err_o, m0_err_o};
      advance();
    end

    rst = 1'b0; mc = 2'b00; ms = 2'b00; sack = 1'b0; serr = 1'b0;
    settle(); advance();
    settle(); advance();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
